// File: rtl/pet_pkg.sv
// Shared definitions for the pet needs engine: action codes, screen ids,
// life-cycle states, needs_values field offsets and saturating arithmetic helpers.
package pet_pkg;

  localparam logic [2:0] ACT_FEED    = 3'd0;
  localparam logic [2:0] ACT_SLEEP   = 3'd1;
  localparam logic [2:0] ACT_WAKE    = 3'd2;
  localparam logic [2:0] ACT_PLAY    = 3'd3;
  localparam logic [2:0] ACT_HEAL    = 3'd4;
  localparam logic [2:0] ACT_RESTART = 3'd7;

  localparam logic [3:0] SCR_MAIN  = 4'd0;
  localparam logic [3:0] SCR_EAT   = 4'd1;
  localparam logic [3:0] SCR_SLEEP = 4'd2;
  localparam logic [3:0] SCR_PLAY  = 4'd3;
  localparam logic [3:0] SCR_HEAL  = 4'd4;
  localparam logic [3:0] SCR_DEAD  = 4'd5;

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } pet_state_e;

  localparam int NV_HEALTH_LSB = 0;
  localparam int NV_FUN_LSB    = 8;
  localparam int NV_ENERGY_LSB = 16;
  localparam int NV_HUNGER_LSB = 24;
  localparam int NV_ALIVE_BIT  = 32;

  // clamp(v + gain - dec, 0, 255); 10-bit signed covers -255..510
  function automatic logic [7:0] sat_update(logic [7:0] v, logic [7:0] gain, logic [7:0] dec);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) + $signed({2'b00, gain}) - $signed({2'b00, dec});
    if (s < 10'sd0) return 8'd0;
    else if (s > 10'sd255) return 8'hFF;
    else return s[7:0];
  endfunction

  function automatic logic [2:0] count_low(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                           logic [7:0] d, logic [7:0] th);
    return 3'(a < th) + 3'(b < th) + 3'(c < th) + 3'(d < th);
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Game tick generator: one-cycle tick every TICK_CYCLES clocks, or every
// TICK_CYCLES/10 clocks in test_mode; any test_mode change restarts the count.
module pet_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic test_mode,
  output logic tick
);

  localparam int FAST = (TICK_CYCLES / 10 > 0) ? TICK_CYCLES / 10 : 1;
  localparam int CW   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic          tm_q;

  assign limit = test_mode ? CW'(FAST - 1) : CW'(TICK_CYCLES - 1);
  assign tick  = (cnt == limit) && (test_mode == tm_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tm_q <= test_mode;
    end else begin
      tm_q <= test_mode;
      if ((test_mode != tm_q) || tick) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pet_needs_engine.sv
// Pet game-state engine: four decaying needs, user actions with ack handshake,
// ALIVE/SLEEPING/DEAD life cycle, packed outputs for the display controller.
module pet_needs_engine
  import pet_pkg::*;
#(
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int DECAY_HUNGER = 3,
  parameter int DECAY_ENERGY = 5,
  parameter int DECAY_FUN    = 4,
  parameter int ACTION_GAIN  = 40,
  parameter int LOW_THRESH   = 50,
  parameter int ANIM_TICKS   = 3,
  parameter int INIT_VALUE   = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        test_mode,
  input  logic        action_valid,
  input  logic [2:0]  action_code,
  output logic        action_ack,
  output logic [32:0] needs_values,
  output logic [8:0]  screen_param,
  output logic        update
);

  // state       | meaning
  // ST_ALIVE    | needs decay, feed/play/heal/sleep applied
  // ST_SLEEPING | energy +1 per tick, wake or full energy returns to ALIVE
  // ST_DEAD     | needs frozen, only restart is applied

  localparam logic [7:0] INIT      = 8'(INIT_VALUE);
  localparam logic [7:0] GAIN      = 8'(ACTION_GAIN);
  localparam logic [7:0] THR       = 8'(LOW_THRESH);
  localparam logic [7:0] ANIM      = 8'(ANIM_TICKS);
  localparam logic [7:0] RL_H      = 8'(DECAY_HUNGER);
  localparam logic [7:0] RL_E      = 8'(DECAY_ENERGY);
  localparam logic [7:0] RL_F      = 8'(DECAY_FUN);
  localparam logic [7:0] PLAY_COST = 8'd10;

  logic tick;

  pet_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .test_mode (test_mode),
    .tick      (tick)
  );

  pet_state_e state_q, state_n;
  logic [7:0] hunger_q, energy_q, fun_q, health_q;
  logic [7:0] hunger_n, energy_n, fun_n, health_n;
  logic [7:0] dh_q, de_q, df_q, dh_n, de_n, df_n;
  logic [7:0] anim_q, anim_n;
  logic [3:0] scr_q, scr_n;
  logic [2:0] mood_q, mood_n;
  logic [1:0] frame_q, frame_n;
  logic       ack_q, upd_q, upd_n;
  logic       take, restart, alive_q, alive_n;
  logic [7:0] g_h, g_e, g_f, g_hl, d_h, d_e, d_f, d_hl;

  assign alive_q = (state_q != ST_DEAD);
  assign alive_n = (state_n != ST_DEAD);

  always_comb begin
    state_n = state_q;
    scr_n   = scr_q;
    anim_n  = anim_q;
    frame_n = frame_q;
    dh_n    = dh_q;
    de_n    = de_q;
    df_n    = df_q;
    g_h = '0; g_e = '0; g_f = '0; g_hl = '0;
    d_h = '0; d_e = '0; d_f = '0; d_hl = '0;
    restart = 1'b0;
    take    = action_valid && !ack_q;

    if (tick) frame_n = frame_q + 2'd1;

    if (tick && alive_q) begin
      dh_n = (dh_q <= 8'd1) ? RL_H : dh_q - 8'd1;
      d_h  = (dh_q <= 8'd1) ? 8'd1 : 8'd0;
      df_n = (df_q <= 8'd1) ? RL_F : df_q - 8'd1;
      d_f  = (df_q <= 8'd1) ? 8'd1 : 8'd0;
      if (state_q == ST_ALIVE) begin
        de_n = (de_q <= 8'd1) ? RL_E : de_q - 8'd1;
        d_e  = (de_q <= 8'd1) ? 8'd1 : 8'd0;
      end else begin
        g_e = 8'd1;
      end
      if (hunger_q == 8'd0 || energy_q == 8'd0 || fun_q == 8'd0) d_hl = 8'd1;
      else if (hunger_q >= THR && energy_q >= THR && fun_q >= THR) g_hl = 8'd1;
      // transient screens count down here; a new action below overrides
      if (scr_q == SCR_EAT || scr_q == SCR_PLAY || scr_q == SCR_HEAL) begin
        if (anim_q <= 8'd1) scr_n = SCR_MAIN;
        else                anim_n = anim_q - 8'd1;
      end
    end

    if (take) begin
      case (state_q)
        ST_ALIVE: begin
          case (action_code)
            ACT_FEED:  begin g_h = GAIN; scr_n = SCR_EAT; anim_n = ANIM; end
            ACT_PLAY:  begin
              g_f    = GAIN;
              d_e    = d_e + PLAY_COST;
              scr_n  = SCR_PLAY;
              anim_n = ANIM;
            end
            ACT_HEAL:  begin g_hl = g_hl + GAIN; scr_n = SCR_HEAL; anim_n = ANIM; end
            ACT_SLEEP: begin state_n = ST_SLEEPING; scr_n = SCR_SLEEP; end
            default:   ;
          endcase
        end
        ST_SLEEPING: begin
          if (action_code == ACT_WAKE) begin
            state_n = ST_ALIVE;
            scr_n   = SCR_MAIN;
          end
        end
        default: begin
          if (action_code == ACT_RESTART) restart = 1'b1;
        end
      endcase
    end

    hunger_n = sat_update(hunger_q, g_h, d_h);
    energy_n = sat_update(energy_q, g_e, d_e);
    fun_n    = sat_update(fun_q, g_f, d_f);
    health_n = sat_update(health_q, g_hl, d_hl);

    if (state_q == ST_SLEEPING && state_n == ST_SLEEPING && energy_n == 8'hFF) begin
      state_n = ST_ALIVE;
      scr_n   = SCR_MAIN;
    end
    if (alive_q && health_n == 8'd0) begin
      state_n = ST_DEAD;
      scr_n   = SCR_DEAD;
    end

    if (restart) begin
      state_n  = ST_ALIVE;
      scr_n    = SCR_MAIN;
      anim_n   = '0;
      frame_n  = '0;
      hunger_n = INIT;
      energy_n = INIT;
      fun_n    = INIT;
      health_n = INIT;
      dh_n     = RL_H;
      de_n     = RL_E;
      df_n     = RL_F;
    end

    mood_n = count_low(hunger_n, energy_n, fun_n, health_n, THR);
    upd_n  = {alive_n, hunger_n, energy_n, fun_n, health_n, scr_n, mood_n, frame_n} !=
             {alive_q, hunger_q, energy_q, fun_q, health_q, scr_q, mood_q, frame_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ALIVE;
      hunger_q <= INIT;
      energy_q <= INIT;
      fun_q    <= INIT;
      health_q <= INIT;
      dh_q     <= RL_H;
      de_q     <= RL_E;
      df_q     <= RL_F;
      anim_q   <= '0;
      scr_q    <= SCR_MAIN;
      mood_q   <= '0;
      frame_q  <= '0;
      ack_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      hunger_q <= hunger_n;
      energy_q <= energy_n;
      fun_q    <= fun_n;
      health_q <= health_n;
      dh_q     <= dh_n;
      de_q     <= de_n;
      df_q     <= df_n;
      anim_q   <= anim_n;
      scr_q    <= scr_n;
      mood_q   <= mood_n;
      frame_q  <= frame_n;
      ack_q    <= take;
      upd_q    <= upd_n;
    end
  end

  assign action_ack   = ack_q;
  assign update       = upd_q;
  assign needs_values = {alive_q, hunger_q, energy_q, fun_q, health_q};
  assign screen_param = {scr_q, mood_q, frame_q};

endmodule

// File: tb/tb_pet_needs_engine.sv
// Self-checking bench for pet_needs_engine: action vectors through a scoreboard
// plus hand-written sequences for ticks, test_mode, reset and the death path.
module tb_pet_needs_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, tm_a, av_a, ack_a, upd_a;
  logic [2:0]  ac_a;
  logic [32:0] nv_a;
  logic [8:0]  sp_a;
  logic        rst_b, tm_b, av_b, ack_b, upd_b;
  logic [2:0]  ac_b;
  logic [32:0] nv_b;
  logic [8:0]  sp_b;

  pet_needs_engine #(.TICK_CYCLES(10)) dut_a (
    .clk(clk), .rst(rst_a), .test_mode(tm_a), .action_valid(av_a), .action_code(ac_a),
    .action_ack(ack_a), .needs_values(nv_a), .screen_param(sp_a), .update(upd_a)
  );

  pet_needs_engine #(.TICK_CYCLES(10), .INIT_VALUE(2)) dut_b (
    .clk(clk), .rst(rst_b), .test_mode(tm_b), .action_valid(av_b), .action_code(ac_b),
    .action_ack(ack_b), .needs_values(nv_b), .screen_param(sp_b), .update(upd_b)
  );

  typedef struct {
    int          dut;
    logic [32:0] needs;
    logic [3:0]  scr;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  code;
    logic [32:0] needs;
    logic [3:0]  scr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[11];

  int cyc = 0;
  int base = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [32:0] nv(bit al, int h, int e, int f, int hl);
    return {al, 8'(h), 8'(e), 8'(f), 8'(hl)};
  endfunction

  function automatic logic [8:0] sp(int id, int mood, int frame);
    return {4'(id), 3'(mood), 2'(frame)};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc - base, act, exp);
    end
  endtask

  task automatic do_reset(int d);
    @(negedge clk);
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    @(negedge clk);
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
    base = cyc;
  endtask

  task automatic wait_cyc(int c);
    while (cyc - base < c) @(negedge clk);
  endtask

  // raise valid in cycle c, expect ack with the new state exactly one cycle later
  task automatic send_action(int d, int c, logic [2:0] code, logic [32:0] en, logic [3:0] es);
    exp_t e;
    logic got;
    wait_cyc(c);
    e.dut = d; e.needs = en; e.scr = es;
    sb.push_back(e);
    if (d == 0) begin av_a = 1'b1; ac_a = code; end
    else        begin av_b = 1'b1; ac_b = code; end
    @(negedge clk);
    got = (d == 0) ? ack_a : ack_b;
    chk("ack_latency", 64'(got), 64'(1));
    if (!got) void'(sb.pop_front());
    if (d == 0) av_a = 1'b0; else av_b = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_ack @cycle %0d: ack with %0d pending, expected none", cyc - base, sb.size());
        end else begin
          e = sb.pop_front();
          if (e.dut == 0) begin
            chk("sb_needs_a", 64'(nv_a), 64'(e.needs));
            chk("sb_screen_a", 64'(sp_a[8:5]), 64'(e.scr));
          end else begin
            chk("sb_needs_b", 64'(nv_b), 64'(e.needs));
            chk("sb_screen_b", 64'(sp_b[8:5]), 64'(e.scr));
          end
        end
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; tm_a = 1'b0; av_a = 1'b0; ac_a = 3'd0;
    rst_b = 1'b1; tm_b = 1'b0; av_b = 1'b0; ac_b = 3'd0;

    tbl[0]  = '{29,  3'd0, nv(1, 239, 200, 200, 203), 4'd1};
    tbl[1]  = '{35,  3'd0, nv(1, 255, 200, 200, 203), 4'd1};
    tbl[2]  = '{42,  3'd3, nv(1, 255, 190, 239, 204), 4'd3};
    tbl[3]  = '{49,  3'd4, nv(1, 255, 189, 239, 245), 4'd4};
    tbl[4]  = '{52,  3'd2, nv(1, 255, 189, 239, 245), 4'd4};
    tbl[5]  = '{55,  3'd5, nv(1, 255, 189, 239, 245), 4'd4};
    tbl[6]  = '{57,  3'd4, nv(1, 255, 189, 239, 255), 4'd4};
    tbl[7]  = '{59,  3'd1, nv(1, 254, 189, 239, 255), 4'd2};
    tbl[8]  = '{112, 3'd3, nv(1, 253, 194, 238, 255), 4'd2};
    tbl[9]  = '{114, 3'd2, nv(1, 253, 194, 238, 255), 4'd0};
    tbl[10] = '{116, 3'd0, nv(1, 255, 194, 238, 255), 4'd1};

    fork monitor(); join_none

    // reset state, idle ticks, feed handshake and transient screen timeout
    do_reset(0);
    chk("rst_needs", 64'(nv_a), 64'(nv(1, 200, 200, 200, 200)));
    chk("rst_screen", 64'(sp_a), 64'(sp(0, 0, 0)));
    chk("rst_ack", 64'(ack_a), 64'(0));
    chk("rst_update", 64'(upd_a), 64'(0));
    wait_cyc(30);
    chk("idle_needs", 64'(nv_a), 64'(nv(1, 199, 200, 200, 203)));
    chk("idle_screen", 64'(sp_a), 64'(sp(0, 0, 3)));
    chk("idle_update_tick", 64'(upd_a), 64'(1));
    wait_cyc(31);
    chk("idle_update_quiet", 64'(upd_a), 64'(0));
    send_action(0, 32, 3'd0, nv(1, 239, 200, 200, 203), 4'd1);
    chk("feed_update", 64'(upd_a), 64'(1));
    wait_cyc(34);
    chk("feed_ack_drop", 64'(ack_a), 64'(0));
    chk("feed_update_drop", 64'(upd_a), 64'(0));
    wait_cyc(59);
    chk("anim_hold", 64'(sp_a[8:5]), 64'(1));
    wait_cyc(60);
    chk("anim_expire", 64'(sp_a[8:5]), 64'(0));

    // action vectors: saturation, tick-coincident feed, play/heal, sleep/wake
    do_reset(0);
    for (int i = 0; i < 11; i++)
      send_action(0, tbl[i].cyc, tbl[i].code, tbl[i].needs, tbl[i].scr);

    // test_mode: seven fast ticks between two mode changes
    do_reset(0);
    wait_cyc(4);
    tm_a = 1'b1;
    wait_cyc(12);
    tm_a = 1'b0;
    wait_cyc(14);
    chk("tm_needs", 64'(nv_a), 64'(nv(1, 198, 199, 199, 207)));
    chk("tm_screen", 64'(sp_a), 64'(sp(0, 0, 3)));

    // reset while a request is pending and a transient screen is up
    do_reset(0);
    send_action(0, 5, 3'd0, nv(1, 240, 200, 200, 200), 4'd1);
    wait_cyc(8);
    av_a = 1'b1; ac_a = 3'd0; rst_a = 1'b1;
    @(negedge clk);
    chk("midrst_needs", 64'(nv_a), 64'(nv(1, 200, 200, 200, 200)));
    chk("midrst_screen", 64'(sp_a), 64'(sp(0, 0, 0)));
    chk("midrst_ack", 64'(ack_a), 64'(0));
    chk("midrst_update", 64'(upd_a), 64'(0));
    av_a = 1'b0; rst_a = 1'b0;
    @(negedge clk);
    chk("midrst_ack_after", 64'(ack_a), 64'(0));

    // starvation path to DEAD, frozen needs, ignored feed, restart
    do_reset(1);
    wait_cyc(85);
    chk("dead_needs", 64'(nv_b), 64'(nv(0, 0, 1, 0, 0)));
    chk("dead_screen", 64'(sp_b), 64'(sp(5, 4, 0)));
    wait_cyc(100);
    chk("dead_frozen", 64'(nv_b), 64'(nv(0, 0, 1, 0, 0)));
    chk("dead_frame", 64'(sp_b), 64'(sp(5, 4, 2)));
    send_action(1, 102, 3'd0, nv(0, 0, 1, 0, 0), 4'd5);
    send_action(1, 105, 3'd7, nv(1, 2, 2, 2, 2), 4'd0);
    wait_cyc(107);
    chk("restart_screen", 64'(sp_b), 64'(sp(0, 4, 0)));

    wait_cyc(110);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
